// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window MAC: FSM states and default geometry.
package conv_pkg;

  localparam int unsigned DEF_SIZE      = 3;
  localparam int unsigned DEF_WIDTH_BIT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/conv_window_mac_if.sv
// Window MAC bus: element stream from the index generator and the result handshake.
interface conv_window_mac_if
  import conv_pkg::*;
#(
  parameter int unsigned SIZE      = DEF_SIZE,
  parameter int unsigned WIDTH_BIT = DEF_WIDTH_BIT,
  parameter int unsigned ACC_WIDTH = 2*WIDTH_BIT + $clog2(SIZE*SIZE)
);

  logic                        start;
  logic                        ena;
  logic [WIDTH_BIT-1:0]        i;
  logic [WIDTH_BIT-1:0]        j;
  logic                        in_valid;
  logic signed [WIDTH_BIT-1:0] pixel;
  logic signed [WIDTH_BIT-1:0] weight;
  logic signed [ACC_WIDTH-1:0] result;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;
  logic                        error;

  // master drives elements and accepts results; slave is the MAC itself
  modport master (
    output start, i, j, in_valid, pixel, weight, out_ready,
    input  ena, result, out_valid, busy, error
  );

  modport slave (
    input  start, i, j, in_valid, pixel, weight, out_ready,
    output ena, result, out_valid, busy, error
  );

endinterface

// File: rtl/mac_mult.sv
// Combinational signed multiplier producing a full-width product.
module mac_mult #(
  parameter int unsigned WIDTH_BIT = 8
) (
  input  logic signed [WIDTH_BIT-1:0]   a,
  input  logic signed [WIDTH_BIT-1:0]   b,
  output logic signed [2*WIDTH_BIT-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/conv_window_mac.sv
// Accumulates pixel*weight over one SIZE x SIZE window, checks the index
// sequence, and holds the sum until the downstream accepts it.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int unsigned SIZE      = DEF_SIZE,
  parameter int unsigned WIDTH_BIT = DEF_WIDTH_BIT,
  parameter int unsigned ACC_WIDTH = 2*WIDTH_BIT + $clog2(SIZE*SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  conv_window_mac_if.slave bus
);

  localparam int unsigned          PROD_WIDTH = 2*WIDTH_BIT;
  localparam logic [WIDTH_BIT-1:0] LAST       = WIDTH_BIT'(SIZE - 1);

  state_t                       state, state_next;
  logic signed [ACC_WIDTH-1:0]  acc, acc_next;
  logic signed [ACC_WIDTH-1:0]  result_q, result_next;
  logic [WIDTH_BIT-1:0]         ei, ei_next;
  logic [WIDTH_BIT-1:0]         ej, ej_next;
  logic                         error_q, error_next;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic                         in_range;
  logic                         in_order;
  logic                         is_last;

  mac_mult #(.WIDTH_BIT(WIDTH_BIT)) u_mult (
    .a (bus.pixel),
    .b (bus.weight),
    .p (prod)
  );

  // signed cast sign-extends the product into the wider accumulator
  assign acc_sum  = acc + ACC_WIDTH'(prod);
  assign in_range = (bus.i <= LAST) && (bus.j <= LAST);
  assign in_order = (bus.i == ei) && (bus.j == ej);
  assign is_last  = (bus.i == LAST) && (bus.j == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      result_q <= '0;
      ei       <= '0;
      ej       <= '0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      result_q <= result_next;
      ei       <= ei_next;
      ej       <= ej_next;
      error_q  <= error_next;
    end
  end

  always_comb begin
    state_next  = state;
    acc_next    = acc;
    result_next = result_q;
    ei_next     = ei;
    ej_next     = ej;
    error_next  = error_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = ACCUM;
          acc_next   = '0;
          ei_next    = '0;
          ej_next    = '0;
          error_next = 1'b0;
        end
      end

      ACCUM: begin
        if (bus.in_valid) begin
          if (!in_range) begin
            error_next = 1'b1;
          end else begin
            // out-of-order data is still summed; the window end follows (i,j)
            if (!in_order) error_next = 1'b1;
            acc_next = acc_sum;
            if (ej == LAST) begin
              ej_next = '0;
              ei_next = ei + WIDTH_BIT'(1);
            end else begin
              ej_next = ej + WIDTH_BIT'(1);
            end
            if (is_last) begin
              result_next = acc_sum;
              state_next  = HOLD;
            end
          end
        end
      end

      HOLD: begin
        if (bus.out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.ena       = (state == ACCUM);
  assign bus.busy      = (state == ACCUM) || (state == HOLD);
  assign bus.out_valid = (state == HOLD);
  assign bus.result    = result_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac: expected sums are queued as windows are
// driven and compared when the result handshake occurs.
module tb_conv_window_mac;
  import conv_pkg::*;

  localparam int SIZE = 3;
  localparam int WB   = 8;
  localparam int AW   = 2*WB + $clog2(SIZE*SIZE);

  typedef struct {
    longint res;
    logic   err;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  longint m_acc;
  int     m_ei, m_ej;
  logic   m_err;

  conv_window_mac_if #(.SIZE(SIZE), .WIDTH_BIT(WB), .ACC_WIDTH(AW)) bus ();

  conv_window_mac #(.SIZE(SIZE), .WIDTH_BIT(WB), .ACC_WIDTH(AW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // result handshake monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else if (bus.out_ready) begin
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("error", bus.error, 64'(e.err));
      end
    end
  end

  task automatic start_window();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m_acc = 0; m_ei = 0; m_ej = 0; m_err = 1'b0;
    check("ena_accum", bus.ena, 1);
    check("err_clr", bus.error, 0);
  endtask

  task automatic send_elem(input int ii, input int jj, input int p, input int w, input int gap);
    bit last;
    last = 1'b0;
    bus.i = WB'(ii); bus.j = WB'(jj);
    bus.pixel = WB'(p); bus.weight = WB'(w);
    bus.in_valid = 1'b1;
    if (ii >= SIZE || jj >= SIZE) begin
      m_err = 1'b1;
    end else begin
      if (ii != m_ei || jj != m_ej) m_err = 1'b1;
      m_acc += longint'(p * w);
      if (m_ej == SIZE-1) begin m_ej = 0; m_ei++; end
      else m_ej++;
      if (ii == SIZE-1 && jj == SIZE-1) begin
        last = 1'b1;
        sb.push_back('{m_acc, m_err});
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (last) begin
      check("lat_valid", bus.out_valid, 1);
    end else begin
      for (int k = 0; k < gap; k++) begin
        check("ena_gap", bus.ena, 1);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic window_const(input int p, input int w, input int gap);
    start_window();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        send_elem(r, c, p, w, gap);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", sb.size(), 0);
    check("idle", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.i = '0; bus.j = '0; bus.in_valid = 1'b0;
    bus.pixel = '0; bus.weight = '0; bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_result", bus.result, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ena", bus.ena, 0);
    check("rst_error", bus.error, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic and extreme-magnitude windows
    window_const(1, 2, 0);        drain();
    window_const(-128, -128, 0);  drain();
    window_const(-128, 127, 0);   drain();

    // gaps between elements
    window_const(3, -5, 3);       drain();

    // downstream stall with start pulsed while holding
    bus.out_ready = 1'b0;
    window_const(7, 7, 0);
    for (int k = 0; k < 5; k++) begin
      bus.start = (k == 2);
      check("hold_valid", bus.out_valid, 1);
      check("hold_result", bus.result, 441);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("hold_exit_busy", bus.busy, 0);
    check("hold_exit_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check("start_ignored", bus.busy, 0);

    // element 4 presented as (2,2): error, window ends early
    start_window();
    send_elem(0, 0, 1, 1, 0);
    send_elem(0, 1, 2, 3, 0);
    send_elem(0, 2, -4, 5, 0);
    send_elem(1, 0, 6, -7, 0);
    send_elem(2, 2, 8, 9, 0);
    check("seq_err_flag", bus.error, 1);
    drain();

    // out-of-range index is flagged and not accumulated
    start_window();
    send_elem(0, 0, 2, 2, 0);
    send_elem(5, 0, 100, 100, 0);
    check("range_err_flag", bus.error, 1);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        if (r != 0 || c != 0) send_elem(r, c, 1, 1, 0);
    drain();

    // reset mid-window aborts it
    start_window();
    for (int c = 0; c < 4; c++) send_elem(c / SIZE, c % SIZE, 5, 5, 0);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_ena", bus.ena, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_result", bus.result, 0);
    check("abort_error", bus.error, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_valid", bus.out_valid, 0);
    end
    window_const(1, 1, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_mac.md
CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 Parameter SIZE, default 3: kernel/window edge length; one window is SIZE*SIZE elements.
REQ-002 Parameter WIDTH_BIT, default 8: width of pixel, weight, i and j.
REQ-003 Parameter ACC_WIDTH, default 2*WIDTH_BIT+$clog2(SIZE*SIZE): signed accumulator and result width.
REQ-004 clock  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 start  input  1: request to begin one window; sampled only in IDLE.
REQ-007 ena  output  1: advance enable to the upstream index generator; high only in ACCUM.
REQ-008 i, j  input  WIDTH_BIT each: row and column index of the current element, from the upstream index generator.
REQ-009 in_valid  input  1: pixel, weight, i and j are valid this cycle.
REQ-010 pixel, weight  input  WIDTH_BIT each, signed: operands for element (i,j).
REQ-011 result  output  ACC_WIDTH signed: sum of pixel*weight over the window.
REQ-012 out_valid  output  1: result is valid; held until accepted.
REQ-013 out_ready  input  1: downstream accepts result when out_valid && out_ready.
REQ-014 busy  output  1: high in ACCUM or HOLD.
REQ-015 error  output  1: sticky index-sequence error flag.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-017 IDLE with start=1: go to ACCUM next cycle, clear the accumulator, set the expected index (ei,ej) to (0,0) and clear error.
REQ-018 ACCUM with in_valid=1: acc <= acc + sign-extended(pixel*weight), and (ei,ej) advances row-major (ej wraps at SIZE-1, ei increments on the wrap).
REQ-019 ACCUM with in_valid=0: acc, (ei,ej) and state SHALL hold.
REQ-020 A valid element with i==SIZE-1 and j==SIZE-1 SHALL be the final one: accumulate it, load result and go to HOLD; out_valid rises the cycle after that element (latency 1).
REQ-021 HOLD: out_valid=1 and result stable until out_valid && out_ready; return to IDLE the next cycle, with out_valid low.
REQ-022 start SHALL be ignored in ACCUM and HOLD; start in the same cycle as the HOLD handshake SHALL be ignored, so a new window needs start again in IDLE.
REQ-023 If a valid element has (i,j) != (ei,ej), error SHALL be set; accumulation still uses the data; the final-element rule follows (i,j).
REQ-024 If i>=SIZE or j>=SIZE on a valid element, error SHALL be set and the element SHALL NOT be accumulated.
REQ-025 Product: signed WIDTH_BIT x WIDTH_BIT to a 2*WIDTH_BIT result; the accumulator SHALL NOT saturate, because ACC_WIDTH covers the worst case of SIZE*SIZE products.
REQ-026 ena SHALL equal (state==ACCUM) combinationally.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, acc=0, result=0, out_valid=0, busy=0, error=0, ena=0 and (ei,ej)=(0,0).
REQ-028 Reset during ACCUM or HOLD SHALL abort the window; no out_valid SHALL follow until a new start.

Structure
REQ-029 A shared package conv_pkg SHALL hold the FSM state enum (IDLE, ACCUM, HOLD) and the default SIZE/WIDTH_BIT constants.
REQ-030 The signed multiply SHALL live in one sub-module, mac_mult (combinational, parameter WIDTH_BIT); state, accumulator and checker stay in conv_window_mac.

Verification
REQ-031 SIZE=3: start, then 9 in-order valid elements with pixel=1 and weight=2 -> out_valid 1 cycle after the 9th element, result=18, error=0.
REQ-032 All 9 elements with pixel=-128 and weight=-128 -> result=147456, no overflow; all 9 with pixel=-128 and weight=127 -> result=-146304.
REQ-033 out_ready held low 5 cycles in HOLD, with start pulsed -> result and out_valid stable throughout, start ignored, IDLE one cycle after out_ready=1.
REQ-034 in_valid gaps of 3 idle cycles between elements -> same result as a gapless run, ena high throughout ACCUM.
REQ-035 Element 4 presented as (2,2) instead of (1,1) -> error=1, window ends at that element, result = sum of the first 5 products.
REQ-036 reset asserted after 4 elements -> immediate IDLE with all outputs 0; a fresh window of all 1x1 -> result=9.
